// File: rtl/lsu_mem_arb.sv
// Load/store memory arbiter: committed-store write buffer with
// store-to-load forwarding and a single outstanding memory read.
module lsu_mem_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WBUF_DEPTH = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ld_req_valid,
   output logic                          ld_req_ready,
   input  logic [ADDR_W-1:0]             ld_req_addr,
   output logic                          ld_resp_valid,
   output logic [DATA_W-1:0]             ld_resp_data,
   input  logic                          st_req_valid,
   output logic                          st_req_ready,
   input  logic [ADDR_W-1:0]             st_req_addr,
   input  logic [DATA_W-1:0]             st_req_data,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic                          mem_req_we,
   output logic [ADDR_W-1:0]             mem_req_addr,
   output logic [DATA_W-1:0]             mem_req_wdata,
   input  logic                          mem_resp_valid,
   input  logic [DATA_W-1:0]             mem_resp_rdata,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
   output logic                          busy
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, FWD, LD_PEND, RD_WAIT, RESP
   } state_t;

   state_t state, state_d;

   logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
   logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr, idx;
   logic [CW-1:0]     count;
   logic [SW-1:0]     starve;
   logic [ADDR_W-1:0] ld_addr_q;
   logic [DATA_W-1:0] ld_data_q;
   logic              lock_q, lock_we_q;

   logic full, push, st_hs, ld_hs, ld_acc;
   logic gnt_st, gnt_ld, st_pri, can_issue;
   logic fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   assign full   = (count == CW'(WBUF_DEPTH));
   assign push   = st_req_valid && st_req_ready;
   assign ld_acc = ld_req_valid && ld_req_ready;
   assign st_hs  = gnt_st && mem_req_ready;
   assign ld_hs  = gnt_ld && mem_req_ready;

   assign st_req_ready = !full;
   assign ld_req_ready = (state == IDLE);
   assign wbuf_count   = count;
   assign busy         = (state != IDLE) || (count != '0);

   // Walk oldest to youngest so the last hit is the youngest store;
   // a store pushed this cycle is younger still.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < count && wb_addr[idx] == ld_req_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data[idx];
         end
      end
      if (push && st_req_addr == ld_req_addr) begin
         fwd_hit  = 1'b1;
         fwd_data = st_req_data;
      end
   end

   // A stalled request keeps its grant until it handshakes.
   always_comb begin
      can_issue = (state != RD_WAIT) && (state != RESP);
      st_pri    = full || (starve == SW'(STARVE_MAX)) ||
                  (state != LD_PEND);
      gnt_st    = 1'b0;
      gnt_ld    = 1'b0;
      if (lock_q) begin
         gnt_st = lock_we_q;
         gnt_ld = !lock_we_q;
      end else if (can_issue) begin
         gnt_st = (count != '0) && st_pri;
         gnt_ld = (state == LD_PEND) && !gnt_st;
      end
   end

   always_comb begin
      mem_req_valid = gnt_st || gnt_ld;
      mem_req_we    = gnt_st;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      if (gnt_st) begin
         mem_req_addr  = wb_addr[rd_ptr];
         mem_req_wdata = wb_data[rd_ptr];
      end else if (gnt_ld) begin
         mem_req_addr  = ld_addr_q;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (ld_req_valid) state_d = fwd_hit ? FWD : LD_PEND;
         FWD:     state_d = IDLE;
         LD_PEND: if (ld_hs) state_d = RD_WAIT;
         RD_WAIT: if (mem_resp_valid) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ld_resp_valid = (state == FWD) || (state == RESP);
   assign ld_resp_data  = ld_resp_valid ? ld_data_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_addr_q <= '0;
         ld_data_q <= '0;
         lock_q    <= 1'b0;
         lock_we_q <= 1'b0;
         starve    <= '0;
      end else begin
         if (ld_acc) ld_addr_q <= ld_req_addr;
         if (ld_acc && fwd_hit) ld_data_q <= fwd_data;
         else if (state == RD_WAIT && mem_resp_valid)
            ld_data_q <= mem_resp_rdata;
         lock_q    <= mem_req_valid && !mem_req_ready;
         lock_we_q <= mem_req_we;
         if (st_hs) starve <= '0;
         else if (ld_hs && count != '0 && starve != SW'(STARVE_MAX))
            starve <= starve + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            wb_addr[i] <= '0;
            wb_data[i] <= '0;
         end
      end else begin
         if (push) begin
            wb_addr[wr_ptr] <= st_req_addr;
            wb_data[wr_ptr] <= st_req_data;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (st_hs) rd_ptr <= rd_ptr + PW'(1);
         case ({push, st_hs})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/lsu_mem_arb.md
LSU_MEM_ARB -- requirements
Module: lsu_mem_arb

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WBUF_DEPTH, 4, store write-buffer entries (power of 2, >=2)
- STARVE_MAX, 4, load wins allowed over a non-empty write buffer before a store is forced
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock
- rst, in, 1, asynchronous active-low reset
- ld_req_valid, in, 1, load request
- ld_req_ready, out, 1, load request accepted
- ld_req_addr, in, ADDR_W, load address
- ld_resp_valid, out, 1, load data valid pulse
- ld_resp_data, out, DATA_W, load data
- st_req_valid, in, 1, committed-store request
- st_req_ready, out, 1, write buffer not full
- st_req_addr, in, ADDR_W, store address
- st_req_data, in, DATA_W, store data
- mem_req_valid, out, 1, memory request
- mem_req_ready, in, 1, memory accepts request
- mem_req_we, out, 1, 1 = write, 0 = read
- mem_req_addr, out, ADDR_W, memory address
- mem_req_wdata, out, DATA_W, write data
- mem_resp_valid, in, 1, read data returned
- mem_resp_rdata, in, DATA_W, read data
- wbuf_count, out, $clog2(WBUF_DEPTH)+1, buffered store count
- busy, out, 1, load in flight or wbuf_count != 0

Function
REQ-003 Handshakes SHALL complete when valid and ready are both high on a rising clk edge.
REQ-004 The write buffer SHALL be a FIFO. st_req_ready SHALL be (wbuf_count != WBUF_DEPTH). A push and a pop in the same cycle SHALL leave the count unchanged. Pointers SHALL wrap modulo WBUF_DEPTH.
REQ-005 The load FSM SHALL have the states IDLE, FWD, LD_PEND, RD_WAIT and RESP. ld_req_ready SHALL equal (state == IDLE).
REQ-006 On load accept, the address SHALL be compared with all valid buffer entries and with a store accepted in the same cycle; that store counts as older than the load.
- On a match, go to FWD, holding the data of the youngest matching store.
- Otherwise, go to LD_PEND.
REQ-007 FWD SHALL drive ld_resp_valid=1 with the forwarded data for exactly 1 cycle, then return to IDLE, with no memory access. Forward latency is 1 cycle after accept.
REQ-008 The arbiter SHALL issue only when state != RD_WAIT and state != RESP.
- The store at the buffer head wins if the buffer is full, or starve_cnt == STARVE_MAX, or state != LD_PEND.
- Otherwise the pending load wins.
REQ-009 While mem_req_valid=1 and mem_req_ready=0, mem_req_we, mem_req_addr and mem_req_wdata SHALL stay stable and the grant SHALL NOT change.
REQ-010 A store handshake SHALL pop the buffer head. A load handshake SHALL move the FSM from LD_PEND to RD_WAIT. mem_req_valid SHALL be 0 in RD_WAIT and RESP (one outstanding read, no stores).
REQ-011 In RD_WAIT, mem_resp_valid SHALL capture mem_resp_rdata and move the FSM to RESP. RESP SHALL drive ld_resp_valid=1 for 1 cycle, then return to IDLE. mem_resp_valid outside RD_WAIT SHALL be ignored.
REQ-012 starve_cnt SHALL:
- increment, saturating at STARVE_MAX, on each load grant while wbuf_count != 0;
- clear on each store grant.
REQ-013 ld_resp_data SHALL be 0 whenever ld_resp_valid=0.

Reset
REQ-014 While rst=0:
- state=IDLE, buffer empty, starve_cnt=0;
- outputs: ld_resp_valid, mem_req_valid, mem_req_we, wbuf_count, busy, ld_resp_data, mem_req_addr and mem_req_wdata all 0;
- st_req_ready=1 and ld_req_ready=1.
REQ-015 Reset asserted mid-operation SHALL discard buffered stores and any in-flight load. A mem_resp_valid arriving after reset release SHALL be ignored.

Verification
REQ-016 Plain load: load 0x100 accepted at cycle 0, mem_req_ready=1, mem_resp_valid with 0xCAFE at cycle 3 -> mem_req_valid at cycle 1 with we=0, addr=0x100; ld_resp_valid=1 with 0xCAFE at cycle 4 only.
REQ-017 Forwarding: stores (0x40,0x11) then (0x40,0x22) buffered with mem_req_ready=0, then load 0x40 -> ld_resp_data=0x22 one cycle after accept; no read request issued.
REQ-018 Full buffer: 4 stores pushed with mem_req_ready=0 -> wbuf_count=4 and st_req_ready=0; a pending load is not granted until a store pops.
REQ-019 Starvation: 1 store buffered and back-to-back non-matching loads, mem_req_ready=1 -> the store is granted after at most 4 load grants.
REQ-020 Stall stability: mem_req_ready=0 for 5 cycles with a request pending -> mem_req_* payload unchanged across all 5 cycles.
REQ-021 Reset in RD_WAIT: rst=0 for 1 cycle, then mem_resp_valid=1 -> no ld_resp_valid; state IDLE; wbuf_count=0.
